// File: rtl/peripheral_bus_arbiter.sv
// peripheral_bus_arbiter
//   Two-master arbiter for the single peripheral bus. Grants the bus to one
//   master per transaction, with round-robin between simultaneous requesters.
//   Non-granted masters see busy=1 and all-ones read data. A granted
//   transaction that stays busy for TIMEOUT_CYCLES cycles is forcibly
//   completed (busy=0, read data all ones) and counted.
//
// Parameters
//   ADDRESS_WIDTH   peripheral-bus address width
//   TIMEOUT_CYCLES  max consecutive busy cycles under one grant; 0 disables
//
// Ports
//   wb_clk_i, wb_rst_i         clock, asynchronous active-high reset
//   m0_*, m1_*                 master ports (we/oe/address/byteSelect/dataWrite
//                              in, busy/dataRead out)
//   peripheralBus_*            slave-side bus
//   grant                      one-hot current grant {m1,m0}, 2'b00 when idle
//   timeout_o                  one-cycle pulse on forced completion
//   timeoutCount               saturating count of forced completions
module peripheral_bus_arbiter #(
  parameter int unsigned ADDRESS_WIDTH  = 24,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,

  input  logic                     m0_we,
  input  logic                     m0_oe,
  input  logic [ADDRESS_WIDTH-1:0] m0_address,
  input  logic [3:0]               m0_byteSelect,
  input  logic [31:0]              m0_dataWrite,
  output logic                     m0_busy,
  output logic [31:0]              m0_dataRead,

  input  logic                     m1_we,
  input  logic                     m1_oe,
  input  logic [ADDRESS_WIDTH-1:0] m1_address,
  input  logic [3:0]               m1_byteSelect,
  input  logic [31:0]              m1_dataWrite,
  output logic                     m1_busy,
  output logic [31:0]              m1_dataRead,

  output logic                     peripheralBus_we,
  output logic                     peripheralBus_oe,
  output logic [ADDRESS_WIDTH-1:0] peripheralBus_address,
  output logic [3:0]               peripheralBus_byteSelect,
  output logic [31:0]              peripheralBus_dataWrite,
  input  logic                     peripheralBus_busy,
  input  logic [31:0]              peripheralBus_dataRead,

  output logic [1:0]               grant,
  output logic                     timeout_o,
  output logic [7:0]               timeoutCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam bit         TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

  state_t     state, state_next;
  logic       last_grant, last_grant_next;
  logic [7:0] busy_count, busy_count_next;
  logic       req0, req1;
  logic       timeout_hit;

  assign req0 = m0_we | m0_oe;
  assign req1 = m1_we | m1_oe;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      busy_count   <= '0;
      timeoutCount <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      busy_count <= busy_count_next;
      if (timeout_hit && (timeoutCount != 8'hFF))
        timeoutCount <= timeoutCount + 8'd1;
    end
  end

  // Timeout is evaluated against the current grant only; it never moves the
  // grant itself, the master is expected to drop its request.
  assign timeout_hit = TIMEOUT_EN && (state != IDLE) && peripheralBus_busy &&
                       (busy_count == TIMEOUT_LIMIT);

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (req0 && req1) state_next = last_grant ? GRANT0 : GRANT1;
        else if (req0)    state_next = GRANT0;
        else if (req1)    state_next = GRANT1;
      end
      GRANT0: begin
        if (!req0) begin
          last_grant_next = 1'b0;
          state_next      = req1 ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (!req1) begin
          last_grant_next = 1'b1;
          state_next      = req0 ? GRANT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    if ((state == IDLE) || (state_next != state) || !peripheralBus_busy || timeout_hit)
      busy_count_next = '0;
    else
      busy_count_next = busy_count + 8'd1;
  end

  always_comb begin
    peripheralBus_we         = 1'b0;
    peripheralBus_oe         = 1'b0;
    peripheralBus_address    = '0;
    peripheralBus_byteSelect = '0;
    peripheralBus_dataWrite  = '0;
    m0_busy                  = 1'b1;
    m0_dataRead              = '1;
    m1_busy                  = 1'b1;
    m1_dataRead              = '1;
    grant                    = 2'b00;
    timeout_o                = timeout_hit;
    case (state)
      GRANT0: begin
        grant                    = 2'b01;
        peripheralBus_we         = m0_we;
        peripheralBus_oe         = m0_oe;
        peripheralBus_address    = m0_address;
        peripheralBus_byteSelect = m0_byteSelect;
        peripheralBus_dataWrite  = m0_dataWrite;
        m0_busy                  = timeout_hit ? 1'b0 : peripheralBus_busy;
        m0_dataRead              = timeout_hit ? '1 : peripheralBus_dataRead;
      end
      GRANT1: begin
        grant                    = 2'b10;
        peripheralBus_we         = m1_we;
        peripheralBus_oe         = m1_oe;
        peripheralBus_address    = m1_address;
        peripheralBus_byteSelect = m1_byteSelect;
        peripheralBus_dataWrite  = m1_dataWrite;
        m1_busy                  = timeout_hit ? 1'b0 : peripheralBus_busy;
        m1_dataRead              = timeout_hit ? '1 : peripheralBus_dataRead;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// tb_peripheral_bus_arbiter
//   Directed bench for peripheral_bus_arbiter. One instance uses
//   TIMEOUT_CYCLES=4; a second instance with TIMEOUT_CYCLES=0 shares all
//   inputs so the disabled-timeout behaviour is observed on the same traffic.
module tb_peripheral_bus_arbiter;

  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_we, m0_oe, m1_we, m1_oe;
  logic [AW-1:0] m0_address, m1_address;
  logic [3:0]    m0_byteSelect, m1_byteSelect;
  logic [31:0]   m0_dataWrite, m1_dataWrite;
  logic          pb_busy;
  logic [31:0]   pb_dataRead;

  logic          m0_busy, m1_busy;
  logic [31:0]   m0_dataRead, m1_dataRead;
  logic          pb_we, pb_oe;
  logic [AW-1:0] pb_address;
  logic [3:0]    pb_byteSelect;
  logic [31:0]   pb_dataWrite;
  logic [1:0]    grant;
  logic          timeout_o;
  logic [7:0]    timeoutCount;

  logic          n_m0_busy, n_m1_busy;
  logic [31:0]   n_m0_dataRead, n_m1_dataRead;
  logic          n_pb_we, n_pb_oe;
  logic [AW-1:0] n_pb_address;
  logic [3:0]    n_pb_byteSelect;
  logic [31:0]   n_pb_dataWrite;
  logic [1:0]    n_grant;
  logic          n_timeout_o;
  logic [7:0]    n_timeoutCount;

  int unsigned n_compared   = 0;
  int unsigned n_mismatched = 0;

  always #5 clk = ~clk;

  peripheral_bus_arbiter #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_we(m0_we), .m0_oe(m0_oe), .m0_address(m0_address),
    .m0_byteSelect(m0_byteSelect), .m0_dataWrite(m0_dataWrite),
    .m0_busy(m0_busy), .m0_dataRead(m0_dataRead),
    .m1_we(m1_we), .m1_oe(m1_oe), .m1_address(m1_address),
    .m1_byteSelect(m1_byteSelect), .m1_dataWrite(m1_dataWrite),
    .m1_busy(m1_busy), .m1_dataRead(m1_dataRead),
    .peripheralBus_we(pb_we), .peripheralBus_oe(pb_oe),
    .peripheralBus_address(pb_address), .peripheralBus_byteSelect(pb_byteSelect),
    .peripheralBus_dataWrite(pb_dataWrite), .peripheralBus_busy(pb_busy),
    .peripheralBus_dataRead(pb_dataRead),
    .grant(grant), .timeout_o(timeout_o), .timeoutCount(timeoutCount)
  );

  peripheral_bus_arbiter #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(0)) dut_nt (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_we(m0_we), .m0_oe(m0_oe), .m0_address(m0_address),
    .m0_byteSelect(m0_byteSelect), .m0_dataWrite(m0_dataWrite),
    .m0_busy(n_m0_busy), .m0_dataRead(n_m0_dataRead),
    .m1_we(m1_we), .m1_oe(m1_oe), .m1_address(m1_address),
    .m1_byteSelect(m1_byteSelect), .m1_dataWrite(m1_dataWrite),
    .m1_busy(n_m1_busy), .m1_dataRead(n_m1_dataRead),
    .peripheralBus_we(n_pb_we), .peripheralBus_oe(n_pb_oe),
    .peripheralBus_address(n_pb_address), .peripheralBus_byteSelect(n_pb_byteSelect),
    .peripheralBus_dataWrite(n_pb_dataWrite), .peripheralBus_busy(pb_busy),
    .peripheralBus_dataRead(pb_dataRead),
    .grant(n_grant), .timeout_o(n_timeout_o), .timeoutCount(n_timeoutCount)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  rr_exp;
    int unsigned pulses, n_pulses, n_free;

    rst = 1'b1;
    m0_we = 0; m0_oe = 0; m1_we = 0; m1_oe = 0;
    m0_address = '0; m1_address = '0;
    m0_byteSelect = '0; m1_byteSelect = '0;
    m0_dataWrite = '0; m1_dataWrite = '0;
    pb_busy = 0; pb_dataRead = '0;

    // Reset state
    #3;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_timeout_o", 32'(timeout_o), 32'h0);
    check_eq("rst_timeoutCount", 32'(timeoutCount), 32'h0);
    check_eq("rst_pb_we", 32'(pb_we), 32'h0);
    check_eq("rst_pb_oe", 32'(pb_oe), 32'h0);
    check_eq("rst_pb_address", 32'(pb_address), 32'h0);
    check_eq("rst_m0_busy", 32'(m0_busy), 32'h1);
    check_eq("rst_m1_busy", 32'(m1_busy), 32'h1);
    check_eq("rst_m0_dataRead", m0_dataRead, 32'hFFFFFFFF);
    tick();
    rst = 1'b0;

    // Single master read
    m0_oe = 1; m0_address = 24'h000010; m0_byteSelect = 4'hF;
    pb_busy = 0; pb_dataRead = 32'h12345678;
    #1;
    check_eq("sm_idle_grant", 32'(grant), 32'h0);
    check_eq("sm_idle_m0_busy", 32'(m0_busy), 32'h1);
    check_eq("sm_idle_pb_oe", 32'(pb_oe), 32'h0);
    tick();
    check_eq("sm_grant", 32'(grant), 32'h1);
    check_eq("sm_pb_oe", 32'(pb_oe), 32'h1);
    check_eq("sm_pb_address", 32'(pb_address), 32'h000010);
    check_eq("sm_pb_byteSelect", 32'(pb_byteSelect), 32'hF);
    check_eq("sm_m0_busy", 32'(m0_busy), 32'h0);
    check_eq("sm_m0_dataRead", m0_dataRead, 32'h12345678);
    check_eq("sm_m1_busy", 32'(m1_busy), 32'h1);
    check_eq("sm_m1_dataRead", m1_dataRead, 32'hFFFFFFFF);
    m0_oe = 0;
    tick();
    check_eq("sm_release_grant", 32'(grant), 32'h0);

    // Simultaneous requests right after reset: m0 wins
    rst = 1'b1; #1; rst = 1'b0;
    m0_we = 1; m0_address = 24'h000100; m0_dataWrite = 32'hA5A5A5A5;
    m1_oe = 1; m1_address = 24'h000200;
    tick();
    check_eq("tie_grant", 32'(grant), 32'h1);
    check_eq("tie_pb_we", 32'(pb_we), 32'h1);
    check_eq("tie_pb_dataWrite", pb_dataWrite, 32'hA5A5A5A5);
    check_eq("tie_m1_busy", 32'(m1_busy), 32'h1);
    m0_we = 0;
    tick();
    check_eq("handoff_grant", 32'(grant), 32'h2);
    check_eq("handoff_pb_oe", 32'(pb_oe), 32'h1);
    check_eq("handoff_pb_address", 32'(pb_address), 32'h000200);
    m1_oe = 0;
    tick();
    check_eq("handoff_release", 32'(grant), 32'h0);

    // Round-robin: 4 transactions each, granted master drops for one cycle
    m0_oe = 1; m1_oe = 1;
    rr_exp = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("rr_grant_%0d", i), 32'(grant), 32'(rr_exp));
      m0_oe = ~rr_exp[0];
      m1_oe = ~rr_exp[1];
      rr_exp = {rr_exp[0], rr_exp[1]};
    end
    m0_oe = 0; m1_oe = 0;
    tick();
    check_eq("rr_idle", 32'(grant), 32'h0);

    // Timeout at G+4, then a second one coinciding with request drop
    m0_we = 1; pb_busy = 1;
    tick();
    check_eq("to_G_grant", 32'(grant), 32'h1);
    check_eq("to_G_m0_busy", 32'(m0_busy), 32'h1);
    tick(); tick(); tick();
    check_eq("to_G3_timeout_o", 32'(timeout_o), 32'h0);
    check_eq("to_G3_m0_busy", 32'(m0_busy), 32'h1);
    tick();
    check_eq("to_G4_timeout_o", 32'(timeout_o), 32'h1);
    check_eq("to_G4_m0_busy", 32'(m0_busy), 32'h0);
    check_eq("to_G4_m0_dataRead", m0_dataRead, 32'hFFFFFFFF);
    check_eq("to_G4_nt_timeout_o", 32'(n_timeout_o), 32'h0);
    tick();
    check_eq("to_G5_timeout_o", 32'(timeout_o), 32'h0);
    check_eq("to_G5_timeoutCount", 32'(timeoutCount), 32'h1);
    check_eq("to_G5_m0_busy", 32'(m0_busy), 32'h1);
    tick(); tick(); tick(); tick();
    check_eq("to_G9_timeout_o", 32'(timeout_o), 32'h1);
    m0_we = 0;
    tick();
    check_eq("to_drop_grant", 32'(grant), 32'h0);
    check_eq("to_drop_timeoutCount", 32'(timeoutCount), 32'h2);

    // Saturation on the TIMEOUT=4 instance, disabled timeout on the other
    m0_we = 1;
    pulses = 0; n_pulses = 0; n_free = 0;
    for (int c = 0; c < 1600; c++) begin
      tick();
      if (timeout_o) pulses++;
      if (n_timeout_o) n_pulses++;
      if (!n_m0_busy) n_free++;
    end
    check_eq("sat_pulses", pulses, 32'd320);
    check_eq("sat_timeoutCount", 32'(timeoutCount), 32'd255);
    check_eq("nt_pulses", n_pulses, 32'd0);
    check_eq("nt_m0_never_released", n_free, 32'd0);
    check_eq("nt_timeoutCount", 32'(n_timeoutCount), 32'd0);
    m0_we = 0; pb_busy = 0;
    tick();

    // Async reset mid-write
    m1_we = 1; m1_address = 24'hABCDEF; m1_dataWrite = 32'hDEADBEEF;
    tick();
    check_eq("ar_grant", 32'(grant), 32'h2);
    check_eq("ar_pb_we", 32'(pb_we), 32'h1);
    check_eq("ar_pb_dataWrite", pb_dataWrite, 32'hDEADBEEF);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_rst_pb_we", 32'(pb_we), 32'h0);
    check_eq("ar_rst_grant", 32'(grant), 32'h0);
    check_eq("ar_rst_m1_busy", 32'(m1_busy), 32'h1);
    check_eq("ar_rst_timeoutCount", 32'(timeoutCount), 32'h0);
    #1;
    rst = 1'b0;
    m0_oe = 1;
    tick();
    check_eq("ar_tie_grant", 32'(grant), 32'h1);
    m0_oe = 0; m1_we = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
